// File: rtl/regfile_mp_if.sv
// regfile_mp_if
//   Bus bundle for the multi-port register file: read ports, write ports,
//   scoreboard control and pending summary.
//   Modports:
//     master : issue/writeback side, drives addresses, write data and scoreboard controls
//     slave  : the register file, drives rdata, rbusy and pend_any
//   Signals:
//     raddr    NUM_RD*ADDR_W       read addresses, port i at [i*ADDR_W +: ADDR_W]
//     rdata    NUM_RD*DATA_W       read data, port i at [i*DATA_W +: DATA_W]
//     rbusy    NUM_RD              read source pending and not bypassed this cycle
//     we       NUM_WR*DATA_W/8     per-port byte write enables
//     waddr    NUM_WR*ADDR_W       write addresses
//     wdata    NUM_WR*DATA_W       write data
//     sb_set   1                   mark sb_addr pending
//     sb_addr  ADDR_W              register to mark pending
//     sb_flush 1                   clear all pending bits
//     pend_any 1                   OR of all pending bits
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2
);
    localparam int NB = DATA_W / 8;

    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic [NUM_WR*NB-1:0]     we;
    logic [NUM_WR*ADDR_W-1:0] waddr;
    logic [NUM_WR*DATA_W-1:0] wdata;
    logic                     sb_set;
    logic [ADDR_W-1:0]        sb_addr;
    logic                     sb_flush;
    logic                     pend_any;

    modport master (
        output raddr, we, waddr, wdata, sb_set, sb_addr, sb_flush,
        input  rdata, rbusy, pend_any
    );

    modport slave (
        input  raddr, we, waddr, wdata, sb_set, sb_addr, sb_flush,
        output rdata, rbusy, pend_any
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp
//   Multi-port, byte-writable general register file for the dual-issue core.
//   NUM_RD combinational read ports with per-byte write-through bypass,
//   NUM_WR byte-enabled write ports (higher index = younger, wins overlapping
//   bytes), and a pending-write scoreboard flagging reads of registers owned
//   by in-flight long-latency ops.
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  asynchronous reset, active-high
//     bus    regfile_mp_if.slave (read/write ports, scoreboard control, status)
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 4,
    parameter int NUM_WR  = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic          clk,
    input  logic          reset,
    regfile_mp_if.slave   bus
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_next;

    // Read ports: stored value overlaid byte-by-byte with this cycle's writes.
    // Ports are walked oldest to youngest so the younger writer lands last.
    // A write with any byte enabled counts as a bypass for rbusy, even if
    // only some bytes are forwarded.
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] val;
        logic              hit;
        a   = '0;
        val = '0;
        hit = 1'b0;
        bus.rdata = '0;
        bus.rbusy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            a   = bus.raddr[i*ADDR_W +: ADDR_W];
            val = regs[a];
            hit = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.waddr[j*ADDR_W +: ADDR_W] == a) begin
                    if (bus.we[j*NB +: NB] != '0) begin
                        hit = 1'b1;
                    end
                    for (int b = 0; b < NB; b++) begin
                        if (bus.we[j*NB + b]) begin
                            val[b*8 +: 8] = bus.wdata[j*DATA_W + b*8 +: 8];
                        end
                    end
                end
            end
            if ((ZERO_R0 != 0) && (a == '0)) begin
                val = '0;
            end
            // While reset is held the bypass path must not leak write data.
            if (!reset) begin
                bus.rdata[i*DATA_W +: DATA_W] = val;
                bus.rbusy[i] = pending[a] & ~hit;
            end
        end
    end

    // Register array update; same nonblocking ordering trick as the read
    // path so that the youngest port owns overlapping bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                for (int b = 0; b < NB; b++) begin
                    if (bus.we[j*NB + b] &&
                        !((ZERO_R0 != 0) && (bus.waddr[j*ADDR_W +: ADDR_W] == '0))) begin
                        regs[bus.waddr[j*ADDR_W +: ADDR_W]][b*8 +: 8] <=
                            bus.wdata[j*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
    end

    // Scoreboard next state. Order matters: writebacks clear, flush wipes
    // everything, then a new producer sets its bit so it survives both.
    always_comb begin
        pending_next = pending;
        for (int j = 0; j < NUM_WR; j++) begin
            if (bus.we[j*NB +: NB] != '0) begin
                pending_next[bus.waddr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (bus.sb_flush) begin
            pending_next = '0;
        end
        if (bus.sb_set && !((ZERO_R0 != 0) && (bus.sb_addr == '0))) begin
            pending_next[bus.sb_addr] = 1'b1;
        end
        if (ZERO_R0 != 0) begin
            pending_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign bus.pend_any = |pending;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
//   Scoreboard bench for regfile_mp. The driver applies one stimulus per
//   cycle just after the rising edge, computes the expected outputs from a
//   byte-level reference model and queues them; the monitor pops one entry
//   per falling edge and compares it against what the DUT presents.
module tb_regfile_mp;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 4;
    localparam int NUM_WR = 2;
    localparam int DEPTH  = 32;

    logic clk = 1'b0;
    logic reset;

    regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

    regfile_mp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_R0(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_RD*DATA_W-1:0] rdata;
        logic [NUM_RD-1:0]        rbusy;
        logic                     pend_any;
        string                    tag;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: plain register contents and a pending flag per register.
    logic [31:0] mem [DEPTH];
    bit          pend [DEPTH];

    // Current stimulus for this cycle.
    logic [4:0]  s_raddr [NUM_RD];
    logic [3:0]  s_we    [NUM_WR];
    logic [4:0]  s_waddr [NUM_WR];
    logic [31:0] s_wdata [NUM_WR];
    logic        s_set, s_flush, s_reset;
    logic [4:0]  s_sbaddr;

    task automatic clearStim();
        for (int i = 0; i < NUM_RD; i++) s_raddr[i] = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            s_we[j] = '0; s_waddr[j] = '0; s_wdata[j] = '0;
        end
        s_set = 1'b0; s_flush = 1'b0; s_reset = 1'b0; s_sbaddr = '0;
    endtask

    // Value of register a as seen this cycle: each byte comes from the
    // youngest enabled writer to a, otherwise from storage. r0 is always 0.
    function automatic logic [31:0] modelRead(input logic [4:0] a);
        logic [31:0] res;
        bit          found;
        if (a == 5'd0) return 32'h0;
        res = mem[a];
        for (int b = 0; b < 4; b++) begin
            found = 1'b0;
            for (int j = NUM_WR - 1; j >= 0; j--) begin
                if (!found && s_waddr[j] == a && s_we[j][b]) begin
                    res[b*8 +: 8] = s_wdata[j][b*8 +: 8];
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    function automatic bit modelWritten(input logic [4:0] a);
        for (int j = 0; j < NUM_WR; j++)
            if (s_we[j] != 4'h0 && s_waddr[j] == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic applyStimulus(input string tag);
        exp_t        e;
        logic [31:0] nv [NUM_WR];
        bit          any;
        reset = s_reset;
        for (int i = 0; i < NUM_RD; i++) bus.raddr[i*ADDR_W +: ADDR_W] = s_raddr[i];
        for (int j = 0; j < NUM_WR; j++) begin
            bus.we[j*4 +: 4]                 = s_we[j];
            bus.waddr[j*ADDR_W +: ADDR_W]    = s_waddr[j];
            bus.wdata[j*DATA_W +: DATA_W]    = s_wdata[j];
        end
        bus.sb_set   = s_set;
        bus.sb_addr  = s_sbaddr;
        bus.sb_flush = s_flush;
        e.tag = tag;
        if (s_reset) begin
            e.rdata = '0; e.rbusy = '0; e.pend_any = 1'b0;
            for (int r = 0; r < DEPTH; r++) begin mem[r] = '0; pend[r] = 1'b0; end
        end else begin
            any = 1'b0;
            for (int r = 0; r < DEPTH; r++) any |= pend[r];
            e.pend_any = any;
            for (int i = 0; i < NUM_RD; i++) begin
                e.rdata[i*DATA_W +: DATA_W] = modelRead(s_raddr[i]);
                e.rbusy[i] = pend[s_raddr[i]] && !modelWritten(s_raddr[i]);
            end
            // State after the coming clock edge.
            for (int j = 0; j < NUM_WR; j++) nv[j] = modelRead(s_waddr[j]);
            for (int j = 0; j < NUM_WR; j++)
                if (s_we[j] != 4'h0 && s_waddr[j] != 5'd0) mem[s_waddr[j]] = nv[j];
            for (int j = 0; j < NUM_WR; j++)
                if (s_we[j] != 4'h0) pend[s_waddr[j]] = 1'b0;
            if (s_flush) for (int r = 0; r < DEPTH; r++) pend[r] = 1'b0;
            if (s_set && s_sbaddr != 5'd0) pend[s_sbaddr] = 1'b1;
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        for (int i = 0; i < NUM_RD; i++) begin
            n_cmp++;
            if (bus.rdata[i*DATA_W +: DATA_W] !== e.rdata[i*DATA_W +: DATA_W]) begin
                n_bad++;
                $display("[TB] FAIL %s rdata[%0d]: got %h expected %h", e.tag, i,
                         bus.rdata[i*DATA_W +: DATA_W], e.rdata[i*DATA_W +: DATA_W]);
            end
        end
        n_cmp++;
        if (bus.rbusy !== e.rbusy) begin
            n_bad++;
            $display("[TB] FAIL %s rbusy: got %b expected %b", e.tag, bus.rbusy, e.rbusy);
        end
        n_cmp++;
        if (bus.pend_any !== e.pend_any) begin
            n_bad++;
            $display("[TB] FAIL %s pend_any: got %b expected %b", e.tag, bus.pend_any, e.pend_any);
        end
    endtask

    // Monitor: one queued expectation per cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checkOutput(e);
            end
        end
    end

    function automatic logic [4:0] pickAddr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom);
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        reset = 1'b1;
        clearStim();
        bus.raddr = '0; bus.we = '0; bus.waddr = '0; bus.wdata = '0;
        bus.sb_set = 1'b0; bus.sb_addr = '0; bus.sb_flush = 1'b0;
        @(posedge clk); #1;

        clearStim(); s_reset = 1'b1;
        applyStimulus("reset_init");
        applyStimulus("reset_hold");

        // Mid-run reset after r5 is written and r2 is pending.
        clearStim(); s_we[0] = 4'hF; s_waddr[0] = 5'd5; s_wdata[0] = 32'hDEADBEEF;
        s_set = 1'b1; s_sbaddr = 5'd2; s_raddr[0] = 5'd5;
        applyStimulus("t1_write_r5");
        clearStim(); s_raddr[0] = 5'd5; s_raddr[1] = 5'd2;
        applyStimulus("t1_read_r5");
        clearStim(); s_reset = 1'b1; s_raddr[0] = 5'd5; s_raddr[1] = 5'd2;
        applyStimulus("t1_reset");
        clearStim(); s_raddr[0] = 5'd5;
        applyStimulus("t1_after_reset");

        // Same-cycle merge, younger port owns the low half.
        clearStim();
        s_we[0] = 4'hF; s_waddr[0] = 5'd3; s_wdata[0] = 32'h11223344;
        s_we[1] = 4'h3; s_waddr[1] = 5'd3; s_wdata[1] = 32'hAAAABBBB;
        s_raddr[0] = 5'd3; s_raddr[2] = 5'd3;
        applyStimulus("t2_merge_bypass");
        clearStim(); s_raddr[0] = 5'd3; s_raddr[3] = 5'd3;
        applyStimulus("t2_merge_stored");

        // Single-byte update.
        clearStim(); s_we[0] = 4'hF; s_waddr[0] = 5'd7; s_wdata[0] = 32'h01020304;
        applyStimulus("t3_init_r7");
        clearStim(); s_we[1] = 4'b0100; s_waddr[1] = 5'd7; s_wdata[1] = 32'hAA55CCDD;
        s_raddr[1] = 5'd7;
        applyStimulus("t3_byte2_bypass");
        clearStim(); s_raddr[1] = 5'd7;
        applyStimulus("t3_byte2_stored");

        // Scoreboard set, busy read, bypass clears busy, bit drops after.
        clearStim(); s_set = 1'b1; s_sbaddr = 5'd9;
        applyStimulus("t4_set_r9");
        clearStim(); s_raddr[0] = 5'd9;
        applyStimulus("t4_busy_r9");
        clearStim(); s_raddr[0] = 5'd9; s_we[0] = 4'h1; s_waddr[0] = 5'd9; s_wdata[0] = 32'h12345699;
        applyStimulus("t4_bypass_r9");
        clearStim(); s_raddr[0] = 5'd9;
        applyStimulus("t4_cleared_r9");

        // Set beats same-cycle clear; flush then set.
        clearStim(); s_set = 1'b1; s_sbaddr = 5'd4;
        s_we[1] = 4'hF; s_waddr[1] = 5'd4; s_wdata[1] = 32'hCAFEF00D;
        applyStimulus("t5_set_vs_write");
        clearStim(); s_raddr[0] = 5'd4;
        applyStimulus("t5_r4_pending");
        clearStim(); s_flush = 1'b1; s_set = 1'b1; s_sbaddr = 5'd6;
        applyStimulus("t5_flush_set");
        clearStim(); s_raddr[0] = 5'd4; s_raddr[1] = 5'd6;
        applyStimulus("t5_only_r6");

        // r0 is hardwired.
        clearStim(); s_flush = 1'b1;
        applyStimulus("t6_flush");
        clearStim();
        s_we[0] = 4'hF; s_waddr[0] = 5'd0; s_wdata[0] = 32'hFFFFFFFF;
        s_we[1] = 4'hF; s_waddr[1] = 5'd0; s_wdata[1] = 32'hFFFFFFFF;
        s_set = 1'b1; s_sbaddr = 5'd0; s_raddr[0] = 5'd0;
        applyStimulus("t6_r0_write");
        clearStim(); s_raddr[0] = 5'd0;
        applyStimulus("t6_r0_after");

        // Randomized traffic concentrated on a few registers to force collisions.
        for (int n = 0; n < 600; n++) begin
            clearStim();
            if ($urandom_range(0, 99) == 0) s_reset = 1'b1;
            for (int i = 0; i < NUM_RD; i++) s_raddr[i] = pickAddr();
            for (int j = 0; j < NUM_WR; j++) begin
                s_we[j]    = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
                s_waddr[j] = pickAddr();
                s_wdata[j] = $urandom;
            end
            s_set    = ($urandom_range(0, 3) == 0);
            s_sbaddr = pickAddr();
            s_flush  = ($urandom_range(0, 29) == 0);
            applyStimulus("random");
        end

        clearStim();
        applyStimulus("drain");
        @(posedge clk); #1;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("[TB] FAIL drain: got %0d queued expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
